// File: rtl/fcpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fcpu_pkg
// Description : Shared widths, opcode encoding and opcode-class helpers
// Revision    : 1.0 - initial release
// ============================================================================
package fcpu_pkg;

    localparam int DATA_W   = 32;
    localparam int INSTR_W  = 6;
    localparam int RSV_ID_W = 4;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    typedef enum logic [INSTR_W-1:0] {
        I_NOP     = 6'd0,
        I_ADD     = 6'd1,
        I_LOAD    = 6'd8,
        I_LOADB   = 6'd9,
        I_LOADR   = 6'd10,
        I_LOADF   = 6'd11,
        I_LOADBF  = 6'd12,
        I_LOADRF  = 6'd13,
        I_STORE   = 6'd16,
        I_STOREB  = 6'd17,
        I_STORER  = 6'd18,
        I_STOREF  = 6'd19,
        I_STOREBF = 6'd20,
        I_STORERF = 6'd21
    } opcode_e;

    function automatic logic is_store_op(input logic [INSTR_W-1:0] opcode);
        case (opcode)
            I_STORE, I_STOREB, I_STORER,
            I_STOREF, I_STOREBF, I_STORERF: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic is_load_op(input logic [INSTR_W-1:0] opcode);
        case (opcode)
            I_LOAD, I_LOADB, I_LOADR,
            I_LOADF, I_LOADBF, I_LOADRF: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

    function automatic logic is_byte_op(input logic [INSTR_W-1:0] opcode);
        case (opcode)
            I_LOADB, I_LOADBF, I_STOREB, I_STOREBF: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_ram.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_ram
// Description : Single-port synchronous word RAM, byte write enables,
//               1-cycle read latency
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_responder
// Description : Load/store responder with in-order, backpressured CDB results
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_responder
    import fcpu_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int RESP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                req_valid,
    input  logic [INSTR_W-1:0]  req_opcode,
    input  logic [RSV_ID_W-1:0] req_rsv_id,
    input  logic [DATA_W-1:0]   req_address,
    input  logic [DATA_W-1:0]   req_data,
    output logic                req_ready,
    output logic [CDB_W-1:0]    o_cdb,
    output logic                o_cdb_valid,
    input  logic                o_cdb_ready
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RD   = 1'b1;

    logic [0:0]          r_state, w_state_next;
    logic [RSV_ID_W-1:0] r_pend_tag;
    logic [1:0]          r_pend_lane;
    logic                r_pend_byte;

    logic [CDB_W-1:0]    r_q [RESP_DEPTH];
    logic [PTR_W-1:0]    r_head, r_tail;
    logic [CNT_W-1:0]    r_count;

    logic                w_accept, w_load_accept, w_is_byte, w_push, w_pop;
    logic [CNT_W:0]      w_occupancy;
    logic [3:0]          w_be;
    logic [DATA_W-1:0]   w_wdata, w_rdata, w_load_data;
    logic                w_unused;

    assign w_unused = ^req_address[DATA_W-1:ADDR_W+2];

    // The pending load counts against capacity so its push can never overflow.
    assign w_occupancy = (CNT_W+1)'(r_count) + (CNT_W+1)'(r_state == S_RD);
    assign req_ready   = nrst && (w_occupancy < (CNT_W+1)'(RESP_DEPTH));

    assign w_accept      = req_valid && req_ready;
    assign w_load_accept = w_accept && is_load_op(req_opcode);
    assign w_is_byte     = is_byte_op(req_opcode);
    assign w_be          = w_is_byte ? (4'b0001 << req_address[1:0]) : 4'b1111;
    assign w_wdata       = w_is_byte ? {4{req_data[7:0]}} : req_data;

    data_memory_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_accept && (is_load_op(req_opcode) || is_store_op(req_opcode))),
        .i_we    (is_store_op(req_opcode)),
        .i_be    (w_be),
        .i_addr  (req_address[ADDR_W+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_pend_tag  <= '0;
            r_pend_lane <= '0;
            r_pend_byte <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load_accept) begin
                r_pend_tag  <= req_rsv_id;
                r_pend_lane <= req_address[1:0];
                r_pend_byte <= w_is_byte;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = w_load_accept ? S_RD : S_IDLE;
            S_RD:    w_state_next = w_load_accept ? S_RD : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_push = 1'b0;
        case (r_state)
            S_RD:    w_push = 1'b1;
            default: w_push = 1'b0;
        endcase
    end

    assign w_load_data = r_pend_byte
                       ? {{(DATA_W-8){1'b0}}, w_rdata[8*r_pend_lane +: 8]}
                       : w_rdata;

    assign o_cdb_valid = (r_count != '0);
    assign w_pop       = o_cdb_valid && o_cdb_ready;
    assign o_cdb       = o_cdb_valid ? r_q[r_head] : '0;

    always_ff @(posedge clk) begin
        if (w_push) r_q[r_tail] <= {r_pend_tag, w_load_data};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= (r_tail == PTR_W'(RESP_DEPTH-1)) ? '0 : r_tail + 1'b1;
            if (w_pop)  r_head <= (r_head == PTR_W'(RESP_DEPTH-1)) ? '0 : r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_responder
// Description : Directed self-checking bench for data_memory_responder
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;
    import fcpu_pkg::*;

    logic                clk = 1'b0;
    logic                nrst;
    logic                req_valid;
    logic [INSTR_W-1:0]  req_opcode;
    logic [RSV_ID_W-1:0] req_rsv_id;
    logic [DATA_W-1:0]   req_address;
    logic [DATA_W-1:0]   req_data;
    logic                req_ready;
    logic [CDB_W-1:0]    o_cdb;
    logic                o_cdb_valid;
    logic                o_cdb_ready;

    int compared   = 0;
    int mismatched = 0;
    logic [CDB_W-1:0] got [$];

    data_memory_responder #(.ADDR_W(10), .RESP_DEPTH(2)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .req_valid   (req_valid),
        .req_opcode  (req_opcode),
        .req_rsv_id  (req_rsv_id),
        .req_address (req_address),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .o_cdb       (o_cdb),
        .o_cdb_valid (o_cdb_valid),
        .o_cdb_ready (o_cdb_ready)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so a pop seen here completes next edge.
    always @(negedge clk) begin
        if (nrst && o_cdb_valid && o_cdb_ready) got.push_back(o_cdb);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic issue(input logic [INSTR_W-1:0] op, input logic [RSV_ID_W-1:0] rsv,
                         input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] data);
        int n = 0;
        #1;
        req_opcode  = op;
        req_rsv_id  = rsv;
        req_address = addr;
        req_data    = data;
        req_valid   = 1'b1;
        while (!req_ready && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (!req_ready) begin
            compared++;
            mismatched++;
            $error("FAIL issue_timeout: observed=req_ready 0 expected=accept of rsv %0d", rsv);
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [RSV_ID_W-1:0] rsv,
                               input logic [DATA_W-1:0] d);
        int n = 0;
        while (got.size() == 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (got.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s: observed=no response expected=%h", tag, {rsv, d});
        end else begin
            check(tag, 64'(got.pop_front()), 64'({rsv, d}));
        end
    endtask

    initial begin
        nrst        = 1'b0;
        req_valid   = 1'b0;
        req_opcode  = '0;
        req_rsv_id  = '0;
        req_address = '0;
        req_data    = '0;
        o_cdb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_valid", 64'(o_cdb_valid), 64'd0);
        check("rst_cdb", 64'(o_cdb), 64'd0);
        #1 nrst = 1'b1;
        @(posedge clk); #1;

        // Store then load: fixed two-cycle latency, one-cycle valid
        issue(I_STORE, 4'd3, 32'h10, 32'hDEADBEEF);
        issue(I_LOAD, 4'd5, 32'h10, 32'h0);
        check("lat_k1", 64'(o_cdb_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_k2_valid", 64'(o_cdb_valid), 64'd1);
        check("lat_k2_cdb", 64'(o_cdb), 64'({4'd5, 32'hDEADBEEF}));
        @(posedge clk); #1;
        check("lat_k3_valid", 64'(o_cdb_valid), 64'd0);
        expect_resp("t1_resp", 4'd5, 32'hDEADBEEF);

        // Byte store and byte load lanes
        issue(I_STOREB, 4'd3, 32'h13, 32'h000000AB);
        issue(I_LOAD, 4'd6, 32'h10, 32'h0);
        expect_resp("t2_word", 4'd6, 32'hABADBEEF);
        issue(I_LOADB, 4'd2, 32'h12, 32'h0);
        expect_resp("t2_byte", 4'd2, 32'h000000AD);

        // Backpressure: third load held, head stable
        o_cdb_ready = 1'b0;
        issue(I_LOAD, 4'd1, 32'h10, 32'h0);
        issue(I_LOAD, 4'd2, 32'h10, 32'h0);
        #1;
        req_opcode = I_LOAD; req_rsv_id = 4'd3; req_address = 32'h10; req_valid = 1'b1;
        check("t3_stall_ready", 64'(req_ready), 64'd0);
        repeat (3) begin
            @(posedge clk); #2;
        end
        check("t3_still_stalled", 64'(req_ready), 64'd0);
        check("t3_head_valid", 64'(o_cdb_valid), 64'd1);
        check("t3_head_stable", 64'(o_cdb), 64'({4'd1, 32'hABADBEEF}));
        check("t3_no_pop", 64'(got.size()), 64'd0);
        o_cdb_ready = 1'b1;
        for (int n = 0; n < 20 && !req_ready; n++) begin
            @(posedge clk); #2;
        end
        check("t3_third_accept", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        expect_resp("t3_r1", 4'd1, 32'hABADBEEF);
        expect_resp("t3_r2", 4'd2, 32'hABADBEEF);
        expect_resp("t3_r3", 4'd3, 32'hABADBEEF);
        repeat (4) @(posedge clk);
        #1;
        check("t3_no_dup", 64'(got.size()), 64'd0);

        // Full queue, then stream 8 loads with the CDB always granted
        o_cdb_ready = 1'b0;
        issue(I_LOAD, 4'd8, 32'h10, 32'h0);
        issue(I_LOAD, 4'd9, 32'h10, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("t4_full_ready", 64'(req_ready), 64'd0);
        o_cdb_ready = 1'b1;
        for (int i = 0; i < 8; i++) issue(I_LOAD, 4'(i), 32'h10, 32'h0);
        expect_resp("t4_r8", 4'd8, 32'hABADBEEF);
        expect_resp("t4_r9", 4'd9, 32'hABADBEEF);
        for (int i = 0; i < 8; i++) expect_resp($sformatf("t4_s%0d", i), 4'(i), 32'hABADBEEF);
        repeat (4) @(posedge clk);
        #1;
        check("t4_drained", 64'(got.size()), 64'd0);

        // Asynchronous reset discards an in-flight load
        issue(I_LOAD, 4'd7, 32'h10, 32'h0);
        #1 nrst = 1'b0;
        #1;
        check("t5_rst_valid", 64'(o_cdb_valid), 64'd0);
        check("t5_rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #2;
        nrst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_stale", 64'(got.size()), 64'd0);
        check("t5_no_stale_valid", 64'(o_cdb_valid), 64'd0);
        issue(I_LOAD, 4'd4, 32'h10, 32'h0);
        expect_resp("t5_ram_kept", 4'd4, 32'hABADBEEF);

        // Address aliasing, byte-load variant, unknown opcode
        issue(I_STORE, 4'd0, 32'h1010, 32'h12345678);
        issue(I_LOAD, 4'd9, 32'h10, 32'h0);
        expect_resp("t6_alias", 4'd9, 32'h12345678);
        issue(I_LOADBF, 4'd10, 32'h11, 32'h0);
        expect_resp("t6_loadbf", 4'd10, 32'h00000056);
        issue(I_ADD, 4'd11, 32'h10, 32'hFFFFFFFF);
        repeat (5) @(posedge clk);
        #1;
        check("t6_unknown_no_resp", 64'(got.size()), 64'd0);
        issue(I_LOADR, 4'd12, 32'h10, 32'h0);
        expect_resp("t6_unknown_no_write", 4'd12, 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
